// File: rtl/gain_multiplier_pkg.sv
// Shared constants, state encoding and helpers for the gain_multiplier stage
// and any later gain/filter stage built on the same normaliser.
package gain_multiplier_pkg;

  localparam int OP_W  = 16;
  localparam int ACC_W = 32;

  localparam logic [OP_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [OP_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL      = 2'd1,
    NORM     = 2'd2,
    WAIT_CLR = 2'd3
  } state_t;

  // Magnitude of a signed operand, one bit wider so |-32768| fits.
  function automatic logic [OP_W:0] abs_ext(input logic [OP_W-1:0] v);
    logic [OP_W:0] e;
    e = {v[OP_W-1], v};
    return v[OP_W-1] ? (~e + {{OP_W{1'b0}}, 1'b1}) : e;
  endfunction

endpackage

// File: rtl/gain_sat_norm.sv
// Combinational Q-format normaliser: floor-shifts a signed product right by
// FRAC_BITS and clips the outcome to the signed 16-bit range.
module gain_sat_norm
  import gain_multiplier_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic signed [ACC_W-1:0] product,
  output logic        [OP_W-1:0]  result,
  output logic                    sat
);

  localparam logic signed [ACC_W-1:0] Q_MAX = 32'sd32767;
  localparam logic signed [ACC_W-1:0] Q_MIN = -32'sd32768;

  logic signed [ACC_W-1:0] q;

  always_comb begin
    // Arithmetic shift gives rounding toward minus infinity.
    q      = product >>> FRAC_BITS;
    result = q[OP_W-1:0];
    sat    = 1'b0;
    if (q > Q_MAX) begin
      result = SAT_MAX;
      sat    = 1'b1;
    end else if (q < Q_MIN) begin
      result = SAT_MIN;
      sat    = 1'b1;
    end
  end

endmodule

// File: rtl/gain_multiplier.sv
// Fixed-gain sequential multiplier: sign-magnitude shift-add, one gain bit per
// clock, saturated result returned over a four-phase data_rdy/result_rdy handshake.
module gain_multiplier
  import gain_multiplier_pkg::*;
#(
  parameter logic signed [15:0] GAIN      = 16'sh0180,
  parameter int                 FRAC_BITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] data,
  input  logic        data_rdy,
  output logic [15:0] result,
  output logic        result_rdy,
  output logic        busy,
  output logic        sat
);

  // Handshake: a request is taken on an IDLE edge with data_rdy=1; result_rdy
  // rises after the NORM edge and drops on the first edge that sees data_rdy=0,
  // so the requester must lower data_rdy before a new request is accepted.

  localparam logic [OP_W:0] MAG_B = abs_ext(GAIN);

  state_t                  state;
  state_t                  state_next;
  logic [OP_W:0]           mag_a;
  logic                    neg;
  logic [ACC_W-1:0]        acc;
  logic [3:0]              cnt;
  logic [ACC_W-1:0]        addend;
  logic signed [ACC_W-1:0] product;
  logic [OP_W-1:0]         norm_result;
  logic                    norm_sat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (data_rdy) state_next = MUL;
      MUL:      if (cnt == 4'd15) state_next = NORM;
      NORM:     state_next = WAIT_CLR;
      WAIT_CLR: if (!data_rdy) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  assign busy    = (state == MUL) || (state == NORM);
  assign addend  = MAG_B[cnt] ? (ACC_W'(mag_a) << cnt) : '0;
  assign product = neg ? -$signed(acc) : $signed(acc);

  gain_sat_norm #(.FRAC_BITS(FRAC_BITS)) u_sat_norm (
    .product (product),
    .result  (norm_result),
    .sat     (norm_sat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mag_a      <= '0;
      neg        <= 1'b0;
      acc        <= '0;
      cnt        <= '0;
      result     <= '0;
      result_rdy <= 1'b0;
      sat        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (data_rdy) begin
            mag_a <= abs_ext(data);
            neg   <= data[15] ^ GAIN[15];
            acc   <= '0;
            cnt   <= '0;
          end
        end
        MUL: begin
          acc <= acc + addend;
          cnt <= cnt + 4'd1;
        end
        NORM: begin
          result     <= norm_result;
          sat        <= norm_sat;
          result_rdy <= 1'b1;
        end
        WAIT_CLR: begin
          if (!data_rdy) result_rdy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gain_multiplier.sv
// Bench for gain_multiplier: directed and random samples against an integer
// reference of floor(data*GAIN/2^FRAC_BITS) with 16-bit clipping.
module tb_gain_multiplier;

  localparam logic signed [15:0] TB_GAIN = 16'sh0180;
  localparam int                 TB_FRAC = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic        data_rdy;
  logic [15:0] result;
  logic        result_rdy;
  logic        busy;
  logic        sat;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected {sat, result} per launched request.
  logic [16:0] exp_q[$];

  gain_multiplier #(.GAIN(TB_GAIN), .FRAC_BITS(TB_FRAC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .data       (data),
    .data_rdy   (data_rdy),
    .result     (result),
    .result_rdy (result_rdy),
    .busy       (busy),
    .sat        (sat)
  );

  // Clock / reset
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [15:0] d);
    longint p, q, div;
    logic [15:0] r;
    div = longint'(1) << TB_FRAC;
    p = longint'($signed(d)) * longint'(TB_GAIN);
    q = p / div;
    if (p < 0 && (p % div) != 0) q = q - 1;
    if (q > 32767)  return {1'b1, 16'h7FFF};
    if (q < -32768) return {1'b1, 16'h8000};
    r = q[15:0];
    return {1'b0, r};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver: call at a falling edge; returns at a falling edge with data_rdy low.
  task automatic run_op(input logic [15:0] d, input int hold_extra,
                        input bit change_mid, input bit drop_early);
    logic [16:0] exp;
    int cycles;
    data     = d;
    data_rdy = 1'b1;
    exp_q.push_back(model(d));
    @(posedge clk);
    @(negedge clk);
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      if (change_mid && cycles == 3) data = 16'h7FFF;
      if (drop_early && cycles == 5) data_rdy = 1'b0;
      @(negedge clk);
    end
    exp = exp_q.pop_front();
    chk("busy_cycles", cycles, 17);
    chk("result_rdy_set", result_rdy, 1'b1);
    chk("result", result, exp[15:0]);
    chk("sat", sat, exp[16]);
    repeat (hold_extra) begin
      @(negedge clk);
      chk("hold_rdy", result_rdy, 1'b1);
      chk("hold_busy", busy, 1'b0);
    end
    data_rdy = 1'b0;
    @(negedge clk);
    chk("result_rdy_clr", result_rdy, 1'b0);
    chk("result_hold", result, exp[15:0]);
    chk("sat_hold", sat, exp[16]);
    chk("idle_busy", busy, 1'b0);
  endtask

  initial begin
    rst_n    = 1'b0;
    data_rdy = 1'b0;
    data     = 16'h0000;
    repeat (2) @(negedge clk);
    chk("rst_result", result, 16'h0000);
    chk("rst_rdy", result_rdy, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sat", sat, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic, negative and floor-rounding cases
    run_op(16'h0100, 0, 1'b0, 1'b0);
    run_op(16'hFF00, 0, 1'b0, 1'b0);
    run_op(16'hFFFF, 0, 1'b0, 1'b0);
    // Saturation bounds
    run_op(16'h7000, 0, 1'b0, 1'b0);
    run_op(16'h8000, 0, 1'b0, 1'b0);
    run_op(16'h5555, 0, 1'b0, 1'b0);
    // Long hold of data_rdy after completion: a single operation only
    run_op(16'h0200, 40, 1'b0, 1'b0);
    // Input change while multiplying is ignored
    run_op(16'h0040, 0, 1'b1, 1'b0);
    // Early release: result_rdy is high for one cycle only
    run_op(16'h0300, 0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of an operation
    data     = 16'h1234;
    data_rdy = 1'b1;
    @(posedge clk);
    repeat (8) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_result", result, 16'h0000);
    chk("midrst_rdy", result_rdy, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_sat", sat, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(16'h0010, 0, 1'b0, 1'b0);

    // Random samples, issued back to back with one low cycle between them
    repeat (16) run_op(16'($urandom_range(0, 65535)), 0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
